// File: rtl/image_pkg.sv
// Shared types and constants for the Sobel line packer.
package image_pkg;

  typedef enum logic [2:0] {IDLE, HDR, DATA, SKIP, PAD} state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned LINE_IDX_W = 15;

  function automatic int unsigned bytes_per_line(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/sobel_line_packer_if.sv
// Pixel stream in, FIFO status in, record bytes out; slave is the packer's view.
interface sobel_line_packer_if;

  logic       sobel;
  logic       sobel_valid;
  logic       sobel_hsync;
  logic       sobel_vsync;
  logic       fifo_afull;
  logic       fifo_full;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sol;
  logic       out_eol;

  modport master (
    output sobel, sobel_valid, sobel_hsync, sobel_vsync, fifo_afull, fifo_full,
    input  out_data, out_valid, out_sol, out_eol
  );

  modport slave (
    input  sobel, sobel_valid, sobel_hsync, sobel_vsync, fifo_afull, fifo_full,
    output out_data, out_valid, out_sol, out_eol
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Registers one sync signal and flags its edges against the registered copy.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_p,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/sobel_line_packer.sv
// Packs the 1-bit Sobel stream into per-line records: 2 header bytes + IMAGE_WIDTH/8 data bytes.
// PACKER_STATS_EN enables the frame_cnt / skip_cnt statistics registers.
module sobel_line_packer
  import image_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 720
) (
  input  logic                clk,
  input  logic                rst_p,
  sobel_line_packer_if.slave  bus,
  output logic                line_skip,
  output logic                overrun,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         skip_cnt
);

  localparam int unsigned PixW = $clog2(IMAGE_WIDTH);
  localparam logic [PixW-1:0] LastPix = PixW'(IMAGE_WIDTH - 1);

  state_e                  state_q;
  logic [PixW-1:0]         pixel_cnt_q;
  logic [LINE_IDX_W-1:0]   line_idx_q;
  logic [7:0]              shift_q;
  logic                    frame_toggle_q;
  logic                    clr_pend_q;

  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic unused_edges;

  sync_edge_detect u_hsync_edge (
    .clk    (clk),
    .rst_p  (rst_p),
    .sig_i  (bus.sobel_hsync),
    .rise_o (hs_rise),
    .fall_o (hs_fall)
  );

  sync_edge_detect u_vsync_edge (
    .clk    (clk),
    .rst_p  (rst_p),
    .sig_i  (bus.sobel_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  assign unused_edges = hs_rise ^ vs_fall;

  logic [LINE_IDX_W-1:0] line_eff;
  logic                  skip_cond, skip_start, abort;
  logic [7:0]            shift_nx, pad_byte;
  logic [3:0]            pad_sh;
  logic                  pad_last;
  logic [PixW-1:0]       pad_next;

  // A pending frame restart zeroes the line index as soon as the block is idle.
  assign line_eff   = (state_q == IDLE && (clr_pend_q || vs_rise)) ? '0 : line_idx_q;
  assign skip_cond  = bus.fifo_afull || ({1'b0, line_eff} >= 16'(IMAGE_HEIGHT));
  assign skip_start = (state_q == IDLE) && bus.sobel_valid && skip_cond;
  assign abort      = hs_fall || vs_rise;
  assign shift_nx   = {shift_q[6:0], bus.sobel};
  // Left-align the partial byte; an empty partial byte shifts out to zero.
  assign pad_sh     = 4'd8 - {1'b0, pixel_cnt_q[2:0]};
  assign pad_byte   = shift_q << pad_sh;
  assign pad_last   = (pixel_cnt_q | PixW'(7)) == LastPix;
  assign pad_next   = (pixel_cnt_q | PixW'(7)) + PixW'(1);

  logic       emit, emit_sol, emit_eol;
  logic [7:0] emit_data;

  always_comb begin
    emit      = 1'b0;
    emit_data = '0;
    emit_sol  = 1'b0;
    emit_eol  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sobel_valid && !skip_cond) begin
          emit      = 1'b1;
          emit_data = {frame_toggle_q, line_eff[14:8]};
          emit_sol  = 1'b1;
        end
      end
      HDR: begin
        emit      = 1'b1;
        emit_data = line_idx_q[7:0];
      end
      DATA: begin
        if (!abort && bus.sobel_valid && pixel_cnt_q[2:0] == 3'd7) begin
          emit      = 1'b1;
          emit_data = shift_nx;
          emit_eol  = (pixel_cnt_q == LastPix);
        end
      end
      PAD: begin
        emit      = 1'b1;
        emit_data = pad_byte;
        emit_eol  = pad_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q        <= IDLE;
      pixel_cnt_q    <= '0;
      line_idx_q     <= '0;
      shift_q        <= '0;
      frame_toggle_q <= 1'b0;
      clr_pend_q     <= 1'b0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sol    <= 1'b0;
      bus.out_eol    <= 1'b0;
      line_skip      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      // A byte refused by a full FIFO is dropped but still counted.
      bus.out_valid <= emit & ~bus.fifo_full;
      bus.out_data  <= (emit & ~bus.fifo_full) ? emit_data : 8'h00;
      bus.out_sol   <= emit_sol & ~bus.fifo_full;
      bus.out_eol   <= emit_eol & ~bus.fifo_full;
      if (emit && bus.fifo_full) overrun <= 1'b1;
      line_skip <= 1'b0;
      if (vs_rise) begin
        frame_toggle_q <= ~frame_toggle_q;
        clr_pend_q     <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.sobel_valid) begin
            shift_q     <= shift_nx;
            pixel_cnt_q <= PixW'(1);
            line_idx_q  <= line_eff;
            clr_pend_q  <= 1'b0;
            if (skip_start) begin
              state_q   <= SKIP;
              line_skip <= 1'b1;
            end else begin
              state_q <= HDR;
            end
          end else if (clr_pend_q) begin
            line_idx_q <= '0;
            clr_pend_q <= 1'b0;
          end
        end
        HDR: begin
          if (abort) begin
            state_q <= PAD;
          end else begin
            state_q <= DATA;
            if (bus.sobel_valid) begin
              shift_q     <= shift_nx;
              pixel_cnt_q <= pixel_cnt_q + PixW'(1);
            end
          end
        end
        DATA: begin
          if (abort) begin
            state_q <= PAD;
          end else if (bus.sobel_valid) begin
            shift_q <= shift_nx;
            if (pixel_cnt_q == LastPix) begin
              state_q     <= IDLE;
              pixel_cnt_q <= '0;
              line_idx_q  <= line_idx_q + LINE_IDX_W'(1);
            end else begin
              pixel_cnt_q <= pixel_cnt_q + PixW'(1);
            end
          end
        end
        SKIP: begin
          if (hs_fall || (bus.sobel_valid && pixel_cnt_q == LastPix)) begin
            state_q     <= IDLE;
            pixel_cnt_q <= '0;
            line_idx_q  <= line_idx_q + LINE_IDX_W'(1);
          end else if (bus.sobel_valid) begin
            pixel_cnt_q <= pixel_cnt_q + PixW'(1);
          end
        end
        PAD: begin
          pixel_cnt_q <= pad_next;
          if (pad_last) begin
            state_q     <= IDLE;
            pixel_cnt_q <= '0;
            line_idx_q  <= line_idx_q + LINE_IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PACKER_STATS_EN
  logic [15:0] frame_cnt_q, skip_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_p) begin
      frame_cnt_q <= '0;
      skip_cnt_q  <= '0;
    end else begin
      if (vs_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (skip_start) skip_cnt_q <= skip_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign skip_cnt  = skip_cnt_q;
`else
  assign frame_cnt = '0;
  assign skip_cnt  = '0;
`endif

endmodule

// File: tb/tb_sobel_line_packer.sv
// Randomized scoreboard bench for sobel_line_packer with a line-level reference model.
module tb_sobel_line_packer;
  import image_pkg::*;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int BPL = W / 8;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        line_skip, overrun;
  logic [15:0] frame_cnt, skip_cnt;

  always #5 clk = ~clk;

  sobel_line_packer_if bus ();

  sobel_line_packer #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .rst_p     (rst_p),
    .bus       (bus),
    .line_skip (line_skip),
    .overrun   (overrun),
    .frame_cnt (frame_cnt),
    .skip_cnt  (skip_cnt)
  );

  typedef struct {
    logic [7:0] data;
    bit         sol;
    bit         eol;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   skip_seen = 0;

  // Reference model state
  bit m_tog;
  int m_line, m_frame, m_skip, exp_skips;
  bit m_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_p) begin
      if (line_skip) skip_seen++;
      if (bus.out_valid) begin
        nvec++;
        if (expq.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_byte: got data=%02h sol=%0b eol=%0b at cycle %0d, expected none",
                   bus.out_data, bus.out_sol, bus.out_eol, cyc);
        end else begin
          mon_e = expq.pop_front();
          if (bus.out_data !== mon_e.data || bus.out_sol !== mon_e.sol ||
              bus.out_eol !== mon_e.eol || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
            nerr++;
            $display("FAIL record_byte: got data=%02h sol=%0b eol=%0b cycle=%0d, expected data=%02h sol=%0b eol=%0b cycle=%0d",
                     bus.out_data, bus.out_sol, bus.out_eol, cyc,
                     mon_e.data, mon_e.sol, mon_e.eol, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic int stat(input int v);
`ifdef PACKER_STATS_EN
    return v % 65536;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] pack_byte(input logic [15:0] pix, input int npix, input int j);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (8 * j + k < npix) b[7-k] = pix[15-(8*j+k)];
    end
    return b;
  endfunction

  task automatic push(input logic [7:0] d, input bit s, input bit e, input int c);
    exp_t x;
    x.data = d; x.sol = s; x.eol = e; x.cyc = c;
    expq.push_back(x);
  endtask

  task automatic drive_idle();
    bus.sobel_valid = 1'b0;
    bus.sobel_hsync = 1'b0;
    bus.sobel_vsync = 1'b0;
    bus.sobel       = 1'b0;
    bus.fifo_afull  = 1'b0;
    bus.fifo_full   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  task automatic do_vsync();
    @(posedge clk); #1;
    bus.sobel_vsync = 1'b1;
    @(posedge clk); #1;
    bus.sobel_vsync = 1'b0;
    m_tog   = ~m_tog;
    m_frame++;
    m_line  = 0;
    idle(2);
  endtask

  // Pixel i of the line is pix[15-i]; drop_j names a data byte refused by the FIFO.
  task automatic run_line(input logic [15:0] pix, input int npix, input bit afull,
                          input int drop_j, input bit gaps);
    int        n0;
    bit        timed;
    logic [14:0] ml;
    @(posedge clk); #1;
    n0    = cyc;
    ml    = 15'(m_line);
    timed = (npix == W) && !gaps;
    if (afull || m_line >= H) begin
      exp_skips++;
      m_skip++;
    end else begin
      push({m_tog, ml[14:8]}, 1'b1, 1'b0, timed ? n0 + 1 : -1);
      push(ml[7:0], 1'b0, 1'b0, timed ? n0 + 2 : -1);
      for (int j = 0; j < BPL; j++) begin
        if (j == drop_j) m_ovr = 1'b1;
        else push(pack_byte(pix, npix, j), 1'b0, j == BPL - 1, timed ? n0 + 8 * j + 8 : -1);
      end
    end
    m_line = (m_line + 1) % 32768;
    for (int i = 0; i < npix; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            bus.sobel_valid = 1'b0;
            bus.fifo_full   = 1'b0;
            bus.fifo_afull  = 1'b0;
            @(posedge clk); #1;
          end
        end
      end
      bus.sobel_valid = 1'b1;
      bus.sobel_hsync = 1'b1;
      bus.sobel       = pix[15-i];
      bus.fifo_afull  = (i == 0) && afull;
      bus.fifo_full   = (drop_j >= 0) && (i == 8 * drop_j + 7);
    end
    idle(BPL + 4);
  endtask

  initial begin
    #500000;
    nerr++;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pix;
    int          n0, npix, drop;
    bit          full, gaps, afull;

    m_tog = 0; m_line = 0; m_frame = 0; m_skip = 0; exp_skips = 0; m_ovr = 0;
    drive_idle();
    rst_p = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_out_sol", 32'(bus.out_sol), 0);
    check("reset_out_eol", 32'(bus.out_eol), 0);
    check("reset_out_data", 32'(bus.out_data), 0);
    check("reset_line_skip", 32'(line_skip), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_frame_cnt", 32'(frame_cnt), 0);
    check("reset_skip_cnt", 32'(skip_cnt), 0);
    @(posedge clk); #1;
    rst_p = 1'b0;
    idle(2);

    // Directed: packing, headers, skip, short line, drop, height limit
    run_line(16'b1010_0000_1111_0001, W, 1'b0, -1, 1'b0);
    do_vsync();
    run_line(16'(($urandom)), W, 1'b0, -1, 1'b0);
    run_line(16'(($urandom)), W, 1'b1, -1, 1'b0);
    check("skip_cnt_after_afull", 32'(skip_cnt), 32'(stat(m_skip)));
    run_line(16'(($urandom)), W, 1'b0, -1, 1'b0);
    run_line(16'hF800, 5, 1'b0, -1, 1'b0);
    do_vsync();
    run_line(16'(($urandom)), W, 1'b0, 0, 1'b0);
    check("overrun_set", 32'(overrun), 1);
    for (int l = 1; l < H; l++) run_line(16'(($urandom)), W, 1'b0, -1, 1'b0);
    check("overrun_sticky", 32'(overrun), 1);
    run_line(16'(($urandom)), W, 1'b0, -1, 1'b0);
    check("skip_pulses_height", 32'(skip_seen), 32'(exp_skips));
    do_vsync();
    check("frame_cnt_after_vsync", 32'(frame_cnt), 32'(stat(m_frame)));
    run_line(16'(($urandom)), W, 1'b0, -1, 1'b0);

    // Randomized lines
    for (int l = 0; l < 40; l++) begin
      if (m_line >= H || $urandom_range(0, 9) == 0) do_vsync();
      full  = $urandom_range(0, 9) < 7;
      npix  = full ? W : $urandom_range(1, W - 1);
      gaps  = $urandom_range(0, 3) == 0;
      afull = full && $urandom_range(0, 9) == 0;
      drop  = (full && !gaps && !afull && $urandom_range(0, 5) == 0) ?
              $urandom_range(0, BPL - 1) : -1;
      pix   = 16'($urandom);
      run_line(pix, npix, afull, drop, gaps);
    end

    check("records_drained", 32'(expq.size()), 0);
    check("skip_pulses_total", 32'(skip_seen), 32'(exp_skips));
    check("overrun_final", 32'(overrun), 32'(m_ovr));
    check("frame_cnt_final", 32'(frame_cnt), 32'(stat(m_frame)));
    check("skip_cnt_final", 32'(skip_cnt), 32'(stat(m_skip)));

    // Reset mid-record: only the bytes already emitted appear, no eol
    do_vsync();
    @(posedge clk); #1;
    n0  = cyc;
    pix = 16'($urandom);
    push({m_tog, 7'(m_line >> 8)}, 1'b1, 1'b0, n0 + 1);
    push(8'(m_line), 1'b0, 1'b0, n0 + 2);
    push(pack_byte(pix, W, 0), 1'b0, 1'b0, n0 + 8);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      bus.sobel_valid = 1'b1;
      bus.sobel_hsync = 1'b1;
      bus.sobel       = pix[15-i];
    end
    @(posedge clk); #1;
    rst_p = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrec_reset_valid", 32'(bus.out_valid), 0);
    check("midrec_reset_overrun", 32'(overrun), 0);
    check("midrec_reset_frame_cnt", 32'(frame_cnt), 0);
    check("midrec_reset_skip_cnt", 32'(skip_cnt), 0);
    check("midrec_partial_record", 32'(expq.size()), 0);
    @(posedge clk); #1;
    rst_p = 1'b0;
    m_tog = 0; m_line = 0; m_frame = 0; m_skip = 0; m_ovr = 0;
    idle(2);
    run_line(16'($urandom), W, 1'b0, -1, 1'b0);
    check("post_reset_drained", 32'(expq.size()), 0);
    check("post_reset_overrun", 32'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
